// File: rtl/wb_regfile_pkg.sv
// Shared write-back definitions for the MEM/WB buffer, the register file and
// the forwarding unit.
package wb_regfile_pkg;

  localparam int unsigned WB_DATA_W = 16;
  localparam int unsigned WB_ADDR_W = 4;
  localparam int unsigned WB_NREGS  = 2 ** WB_ADDR_W;

  // Bit positions of the write-back control bits inside a flat MEM/WB control word
  localparam int unsigned WB_CTRL_W          = 3;
  localparam int unsigned WB_CTRL_REG_WRITE  = 2;
  localparam int unsigned WB_CTRL_R0_WRITE   = 1;
  localparam int unsigned WB_CTRL_MEM_SOURCE = 0;

  typedef struct packed {
    logic reg_write;
    logic r0_write;
    logic mem_source;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_bypass_mux.sv
// Per-read-port write-through bypass: pending R0 side write beats the pending
// regWrite commit, which beats the stored register value.
module wb_bypass_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic              r0_wr_en,
  input  logic [DATA_W-1:0] r0_data,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = stored;
    if (rd_addr == '0 && r0_wr_en) begin
      rd_data = r0_data;
    end else if (rd_addr == wr_addr && wr_en) begin
      rd_data = wb_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: commits MEM/WB results, exposes bypassed
// read ports and a registered write-back record for forwarding.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic              r0Write,
  input  logic              memSource,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] R0D,
  input  logic [ADDR_W-1:0] rdAddr1,
  input  logic [ADDR_W-1:0] rdAddr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic [DATA_W-1:0] r0Data,
  output logic [DATA_W-1:0] wbData,
  output logic              wbValid_q,
  output logic [ADDR_W-1:0] wbAddr_q,
  output logic [DATA_W-1:0] wbData_q
);

  wb_ctrl_t          ctrl;
  logic [DATA_W-1:0] regs [NREGS];

  assign ctrl.reg_write  = regWrite;
  assign ctrl.r0_write   = r0Write;
  assign ctrl.mem_source = memSource;

  assign wbData = ctrl.mem_source ? DataIn : ALUResult;

  // The R0 write is placed last so it overrides a regWrite targeting R0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ctrl.reg_write) begin
        regs[RA1] <= wbData;
      end
      if (ctrl.r0_write) begin
        regs[0] <= R0D;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbValid_q <= 1'b0;
      wbAddr_q  <= '0;
      wbData_q  <= '0;
    end else begin
      wbValid_q <= ctrl.reg_write;
      wbAddr_q  <= RA1;
      wbData_q  <= wbData;
    end
  end

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_rd1 (
    .rd_addr  (rdAddr1),
    .wr_addr  (RA1),
    .wr_en    (ctrl.reg_write),
    .r0_wr_en (ctrl.r0_write),
    .r0_data  (R0D),
    .wb_data  (wbData),
    .stored   (regs[rdAddr1]),
    .rd_data  (rdData1)
  );

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_rd2 (
    .rd_addr  (rdAddr2),
    .wr_addr  (RA1),
    .wr_en    (ctrl.reg_write),
    .r0_wr_en (ctrl.r0_write),
    .r0_data  (R0D),
    .wb_data  (wbData),
    .stored   (regs[rdAddr2]),
    .rd_data  (rdData2)
  );

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_r0 (
    .rd_addr  ('0),
    .wr_addr  (RA1),
    .wr_en    (ctrl.reg_write),
    .r0_wr_en (ctrl.r0_write),
    .r0_data  (R0D),
    .wb_data  (wbData),
    .stored   (regs[0]),
    .rd_data  (r0Data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reset corner cases, directed vector
// table, then randomized traffic against a behavioural register-file model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite, r0Write, memSource;
  logic [3:0]  RA1, rdAddr1, rdAddr2;
  logic [15:0] ALUResult, DataIn, R0D;
  logic [15:0] rdData1, rdData2, r0Data, wbData, wbData_q;
  logic        wbValid_q;
  logic [3:0]  wbAddr_q;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [15:0] model [16];

  wb_regfile dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .r0Write(r0Write),
    .memSource(memSource), .RA1(RA1), .ALUResult(ALUResult), .DataIn(DataIn),
    .R0D(R0D), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdData1(rdData1),
    .rdData2(rdData2), .r0Data(r0Data), .wbData(wbData), .wbValid_q(wbValid_q),
    .wbAddr_q(wbAddr_q), .wbData_q(wbData_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, r0w, ms;
    logic [3:0]  ra1;
    logic [15:0] alu, din, r0d;
    logic [3:0]  a1, a2;
    logic [15:0] e_wb, e_rd1, e_rd2, e_r0;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic rw, input logic r0w, input logic ms, input logic [3:0] ra,
                       input logic [15:0] alu, input logic [15:0] din, input logic [15:0] r0d,
                       input logic [3:0] a1, input logic [3:0] a2);
    regWrite = rw; r0Write = r0w; memSource = ms; RA1 = ra;
    ALUResult = alu; DataIn = din; R0D = r0d; rdAddr1 = a1; rdAddr2 = a2;
  endtask

  // What a read of address a returns this cycle, from the current inputs and stored state
  function automatic logic [15:0] model_read(input logic [3:0] a);
    logic [15:0] wbv;
    wbv = memSource ? DataIn : ALUResult;
    if (a == 4'd0 && r0Write) return R0D;
    if (regWrite && a == RA1) return wbv;
    return model[a];
  endfunction

  function automatic void model_commit();
    logic [15:0] wbv;
    wbv = memSource ? DataIn : ALUResult;
    if (regWrite) model[RA1] = wbv;
    if (r0Write) model[0] = R0D;
  endfunction

  vec_t vecs [9];

  initial begin
    logic [15:0] e_wb;
    logic        e_valid;
    logic [3:0]  e_addr;

    vecs[0] = '{1,0,0, 4'd3, 16'hAAAA, 16'h5555, 16'h0000, 4'd3, 4'd0, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000};
    vecs[1] = '{1,0,1, 4'd3, 16'hAAAA, 16'h5555, 16'h0000, 4'd3, 4'd3, 16'h5555, 16'h5555, 16'h5555, 16'h0000};
    vecs[2] = '{0,0,0, 4'd7, 16'hBEEF, 16'h0000, 16'h0000, 4'd3, 4'd7, 16'hBEEF, 16'h5555, 16'h0000, 16'h0000};
    vecs[3] = '{1,0,0, 4'd7, 16'hBEEF, 16'h0000, 16'h0000, 4'd7, 4'd3, 16'hBEEF, 16'hBEEF, 16'h5555, 16'h0000};
    vecs[4] = '{1,1,0, 4'd0, 16'h1111, 16'h0000, 16'h2222, 4'd0, 4'd7, 16'h1111, 16'h2222, 16'hBEEF, 16'h2222};
    vecs[5] = '{1,1,1, 4'd9, 16'h0000, 16'h00FF, 16'h0F0F, 4'd9, 4'd0, 16'h00FF, 16'h00FF, 16'h0F0F, 16'h0F0F};
    vecs[6] = '{0,0,0, 4'd9, 16'h1234, 16'h4321, 16'hAAAA, 4'd9, 4'd0, 16'h1234, 16'h00FF, 16'h0F0F, 16'h0F0F};
    vecs[7] = '{0,0,1, 4'd0, 16'h5678, 16'h7777, 16'hBBBB, 4'd7, 4'd3, 16'h7777, 16'hBEEF, 16'h5555, 16'h0F0F};
    vecs[8] = '{0,0,0, 4'd3, 16'hCCCC, 16'h9999, 16'hCCCC, 4'd0, 4'd9, 16'hCCCC, 16'h0F0F, 16'h00FF, 16'h0F0F};

    reset = 1'b1;
    drive(0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Write reg[5], then pull reset mid-cycle: clears immediately
    drive(1, 0, 0, 4'd5, 16'h1234, 16'h0, 16'h0, 4'd5, 4'd0);
    @(posedge clk); #1;
    @(negedge clk) drive(0, 0, 0, 4'd5, 16'h0, 16'h0, 16'h0, 4'd5, 4'd0);
    #1 chk("pre_reset_rd1", rdData1, 16'h1234);
    chk("pre_reset_valid", {15'd0, wbValid_q}, 16'h0001);
    #1 reset = 1'b1;
    #1 chk("async_reset_rd1", rdData1, 16'h0000);
    chk("async_reset_valid", {15'd0, wbValid_q}, 16'h0000);
    chk("async_reset_addr", {12'd0, wbAddr_q}, 16'h0000);
    chk("async_reset_dataq", wbData_q, 16'h0000);
    // A write on an edge while reset is still high is dropped
    drive(1, 1, 0, 4'd5, 16'h9999, 16'h0, 16'h7777, 4'd5, 4'd0);
    @(posedge clk);
    @(negedge clk) begin
      reset = 1'b0;
      drive(0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd5, 4'd0);
    end
    #1 chk("reset_drop_rd5", rdData1, 16'h0000);
    chk("reset_drop_r0", rdData2, 16'h0000);

    for (int i = 0; i < 16; i++) model[i] = 16'h0;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].rw, vecs[i].r0w, vecs[i].ms, vecs[i].ra1, vecs[i].alu,
            vecs[i].din, vecs[i].r0d, vecs[i].a1, vecs[i].a2);
      #1;
      chk($sformatf("vec%0d_wbData", i), wbData, vecs[i].e_wb);
      chk($sformatf("vec%0d_rdData1", i), rdData1, vecs[i].e_rd1);
      chk($sformatf("vec%0d_rdData2", i), rdData2, vecs[i].e_rd2);
      chk($sformatf("vec%0d_r0Data", i), r0Data, vecs[i].e_r0);
      model_commit();
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wbValid_q", i), {15'd0, wbValid_q}, {15'd0, vecs[i].rw});
      chk($sformatf("vec%0d_wbAddr_q", i), {12'd0, wbAddr_q}, {12'd0, vecs[i].ra1});
      chk($sformatf("vec%0d_wbData_q", i), wbData_q, vecs[i].e_wb);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) rdAddr1 = RA1;
      if ($urandom_range(0, 5) == 0) rdAddr2 = 4'd0;
      #1;
      e_wb    = memSource ? DataIn : ALUResult;
      e_valid = regWrite;
      e_addr  = RA1;
      chk("rnd_wbData", wbData, e_wb);
      chk("rnd_rdData1", rdData1, model_read(rdAddr1));
      chk("rnd_rdData2", rdData2, model_read(rdAddr2));
      chk("rnd_r0Data", r0Data, model_read(4'd0));
      model_commit();
      @(posedge clk); #1;
      chk("rnd_wbValid_q", {15'd0, wbValid_q}, {15'd0, e_valid});
      chk("rnd_wbAddr_q", {12'd0, wbAddr_q}, {12'd0, e_addr});
      chk("rnd_wbData_q", wbData_q, e_wb);
    end

    // Final sweep of stored contents with writes disabled
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      drive(0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'(a), 4'(15 - a));
      #1;
      chk($sformatf("sweep_rd1_%0d", a), rdData1, model[a]);
      chk($sformatf("sweep_rd2_%0d", a), rdData2, model[15 - a]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
